// File: rtl/sssp_update_packer_pkg.sv
// Shared types and constants for the SSSP update packer: update record, line
// geometry, pad value and the packer state encoding.
package sssp_update_packer_pkg;

  localparam int UPD_PER_CL = 8;
  localparam int UPD_W      = 64;
  localparam int LINE_W     = UPD_PER_CL * UPD_W;

  typedef struct packed {
    logic [31:0] dst;
    logic [31:0] weight;
  } update_t;

  localparam update_t PAD_UPDATE = '{dst: 32'hFFFF_FFFF, weight: 32'hFFFF_FFFF};

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_IDLE  = 2'd3
  } packer_state_e;

endpackage

// File: rtl/sssp_update_packer_update_line_fifo.sv
// First-word-fall-through line FIFO with a registered head. Total capacity is
// DEPTH entries, including the entry currently presented on o_data.
module update_line_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  logic             w_pop;
  logic             w_push_ok;
  logic [AW-1:0]    w_rd_nxt;
  logic [AW:0]      w_cnt_after_pop;

  assign w_pop           = r_valid & i_ready;
  assign o_full          = (r_count == FULL_CNT);
  assign o_empty         = (r_count == '0);
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_ok       = i_push & (~o_full | w_pop);
  assign w_rd_nxt        = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
  assign w_cnt_after_pop = r_count - {{AW{1'b0}}, w_pop};

  // Storage array; contents are discarded logically by resetting the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and the registered head; new pushes reach the head a cycle later.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_nxt;
      r_wr_ptr <= w_push_ok ? (r_wr_ptr + AW'(1)) : r_wr_ptr;
      r_count  <= w_cnt_after_pop + {{AW{1'b0}}, w_push_ok};
      r_valid  <= (w_cnt_after_pop != '0);
      r_data   <= (w_cnt_after_pop != '0) ? r_mem[w_rd_nxt] : '0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/sssp_update_packer.sv
// Collects per-pipe relaxed updates, compacts them in pipe order into 8-slot
// cache lines and queues finished lines for the host-write path.
module sssp_update_packer
  import sssp_update_packer_pkg::*;
#(
  parameter int NUM_PIPES  = 4,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [NUM_PIPES-1:0]    i_upd_valid,
  input  logic [NUM_PIPES*64-1:0] i_upd_word,
  input  logic                    i_last_input_in,
  output logic [LINE_W-1:0]       o_cl_out,
  output logic                    o_cl_valid,
  input  logic                    i_cl_ready,
  output logic                    o_cl_last,
  output logic [31:0]             o_upd_count,
  output logic                    o_done,
  output logic                    o_overflow
);

  packer_state_e                r_state;
  update_t [UPD_PER_CL-1:0]     r_stage;
  logic [2:0]                   r_fill;
  logic [31:0]                  r_upd_count;
  logic                         r_done;
  logic                         r_overflow;

  update_t [UPD_PER_CL-1:0]     w_cur;
  update_t [UPD_PER_CL-1:0]     w_nxt;
  update_t [UPD_PER_CL-1:0]     w_flush_line;
  logic [3:0]                   w_sum;
  logic [3:0]                   w_n;
  logic                         w_complete;
  logic                         w_accum;
  logic                         w_flush;
  logic                         w_push;
  logic                         w_last_push;
  logic [LINE_W-1:0]            w_push_line;
  logic [LINE_W:0]              w_fifo_data;
  logic                         w_fifo_valid;
  logic                         w_fifo_full;
  logic                         w_fifo_empty;
  logic                         w_pop;
  logic                         w_drop;

  // Compaction: each valid update takes position fill+rank; positions 8.. spill into the next line.
  always_comb begin
    w_cur = r_stage;
    w_nxt = '0;
    w_sum = {1'b0, r_fill};
    for (int p = 0; p < NUM_PIPES; p++) begin
      if (i_upd_valid[p]) begin
        if (w_sum[3]) begin
          w_nxt[w_sum[2:0]] = update_t'(i_upd_word[64*p +: 64]);
        end else begin
          w_cur[w_sum[2:0]] = update_t'(i_upd_word[64*p +: 64]);
        end
        w_sum = w_sum + 4'd1;
      end else begin
        w_sum = w_sum;
      end
    end
  end

  assign w_complete = w_sum[3];
  assign w_n        = w_sum - {1'b0, r_fill};
  assign w_accum    = (r_state == ST_ACCUM) & ~i_start;
  assign w_flush    = (r_state == ST_FLUSH) & ~i_start;

  // Final partial line: unused slots carry the pad marker.
  always_comb begin
    w_flush_line = '0;
    for (int i = 0; i < UPD_PER_CL; i++) begin
      if (i < int'(r_fill)) begin
        w_flush_line[i] = r_stage[i];
      end else begin
        w_flush_line[i] = PAD_UPDATE;
      end
    end
  end

  // Selects the line (if any) entering the FIFO this cycle.
  always_comb begin
    if (w_flush) begin
      w_push      = 1'b1;
      w_push_line = w_flush_line;
      w_last_push = 1'b1;
    end else begin
      w_push      = w_accum & w_complete;
      w_push_line = w_cur;
      w_last_push = 1'b0;
    end
  end

  assign w_pop  = w_fifo_valid & i_cl_ready;
  assign w_drop = w_push & w_fifo_full & ~w_pop;

  update_line_fifo #(
    .WIDTH (LINE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  ({w_last_push, w_push_line}),
    .i_ready (i_cl_ready),
    .o_data  (w_fifo_data),
    .o_valid (w_fifo_valid),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Packer state machine with staging line, counters and status flags.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_ACCUM;
      r_stage     <= '0;
      r_fill      <= 3'd0;
      r_upd_count <= 32'd0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (i_start) begin
      r_state     <= ST_ACCUM;
      r_stage     <= '0;
      r_fill      <= 3'd0;
      r_upd_count <= 32'd0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_drop || ((r_state != ST_ACCUM) && (|i_upd_valid))) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ST_ACCUM: begin
          r_upd_count <= r_upd_count + 32'(w_n);
          r_fill      <= w_sum[2:0];
          r_stage     <= w_complete ? w_nxt : w_cur;
          if (i_last_input_in) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          r_fill  <= 3'd0;
          r_stage <= '0;
          r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Empty without seeing the last line means it was dropped: give up on done.
          if (w_pop && w_fifo_data[LINE_W]) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_fifo_empty) begin
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cl_out    = w_fifo_data[LINE_W-1:0];
  assign o_cl_last   = w_fifo_data[LINE_W];
  assign o_cl_valid  = w_fifo_valid;
  assign o_upd_count = r_upd_count;
  assign o_done      = r_done;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_sssp_update_packer.sv
// Self-checking bench for sssp_update_packer: table-driven level sequence,
// directed corner cases and randomized levels against a queue-based line model.
module tb_sssp_update_packer;

  localparam int NP = 4;
  localparam int FD = 64;
  localparam logic [63:0] PAD = 64'hFFFF_FFFF_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [NP-1:0]     upd_valid;
  logic [NP*64-1:0]  upd_word;
  logic              last_in;
  logic              cl_ready;
  logic [511:0]      cl_out;
  logic              cl_valid;
  logic              cl_last;
  logic [31:0]       upd_count;
  logic              done;
  logic              overflow;

  int n_pass  = 0;
  int n_total = 0;

  logic [512:0] got_q[$];
  logic [512:0] exp_q[$];
  logic [63:0]  pend_q[$];

  always #5 clk = ~clk;

  sssp_update_packer #(.NUM_PIPES(NP), .FIFO_DEPTH(FD)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_upd_valid(upd_valid),
    .i_upd_word(upd_word), .i_last_input_in(last_in), .o_cl_out(cl_out),
    .o_cl_valid(cl_valid), .i_cl_ready(cl_ready), .o_cl_last(cl_last),
    .o_upd_count(upd_count), .o_done(done), .o_overflow(overflow)
  );

  typedef struct {
    logic [3:0]  valid;
    logic        last;
    logic        ready;
    logic [31:0] exp_cnt;
    logic        exp_vld;
    logic        exp_last;
    logic        exp_done;
  } vec_t;

  function automatic logic [63:0] uw(input int k);
    return {32'(k + 100), 32'(3 * k + 1)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_line(input string nm, input logic [512:0] act, input logic [512:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Records a pop that the coming edge will perform, then advances one cycle.
  task automatic step();
    if (cl_valid && cl_ready) got_q.push_back({cl_last, cl_out});
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [NP-1:0] v, input logic [NP*64-1:0] w, input logic last);
    upd_valid = v;
    upd_word  = w;
    last_in   = last;
    step();
    upd_valid = '0;
    upd_word  = '0;
    last_in   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic cmp_lines(input string nm);
    chk({nm, "_nlines"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk_line($sformatf("%s_line%0d", nm, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Reference model: updates form one ordered stream, cut every 8.
  task automatic model_accept(input logic [63:0] w);
    logic [512:0] ln;
    pend_q.push_back(w);
    if (pend_q.size() == 8) begin
      ln = '0;
      for (int i = 0; i < 8; i++) ln[64*i +: 64] = pend_q[i];
      exp_q.push_back(ln);
      pend_q.delete();
    end
  endtask

  task automatic model_last();
    logic [512:0] ln;
    ln = '0;
    ln[512] = 1'b1;
    for (int i = 0; i < 8; i++) ln[64*i +: 64] = (i < pend_q.size()) ? pend_q[i] : PAD;
    exp_q.push_back(ln);
    pend_q.delete();
  endtask

  task automatic wait_done(input string nm, input int budget);
    int i;
    cl_ready = 1'b1;
    i = 0;
    while (!done && i < budget) begin
      step();
      i++;
    end
    chk({nm, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    vec_t        tv[6];
    logic [512:0] ln;
    logic [NP*64-1:0] bus;
    logic [31:0] exp_cnt;
    logic [3:0]  m;
    int          k;

    tv[0] = '{4'b1111, 1'b0, 1'b1, 32'd4,  1'b0, 1'b0, 1'b0};
    tv[1] = '{4'b1111, 1'b0, 1'b1, 32'd8,  1'b0, 1'b0, 1'b0};
    tv[2] = '{4'b1111, 1'b1, 1'b1, 32'd12, 1'b1, 1'b0, 1'b0};
    tv[3] = '{4'b0000, 1'b0, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0};
    tv[4] = '{4'b0000, 1'b0, 1'b0, 32'd12, 1'b1, 1'b1, 1'b0};
    tv[5] = '{4'b0000, 1'b0, 1'b1, 32'd12, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; upd_valid = '0; upd_word = '0; last_in = 1'b0; cl_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(cl_valid), 64'd0);
    chk("rst_count", 64'(upd_count), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk_line("rst_line", {cl_last, cl_out}, 513'd0);
    rst_n = 1'b1;
    step();

    // Test 1: single pipe, values 1..8, latency of a completed line.
    do_start();
    cl_ready = 1'b1;
    for (int v = 1; v <= 8; v++) cyc(4'b0001, (NP*64)'(v), 1'b0);
    chk("t1_valid_early", 64'(cl_valid), 64'd0);
    chk("t1_count", 64'(upd_count), 64'd8);
    step();
    ln = '0;
    for (int i = 0; i < 8; i++) ln[64*i +: 64] = 64'(i + 1);
    chk("t1_valid", 64'(cl_valid), 64'd1);
    chk_line("t1_line", {cl_last, cl_out}, ln);
    step();
    got_q.delete();

    // Test 2: table-driven level of 12 updates with end-of-input.
    do_start();
    k = 0;
    for (int t = 0; t < 6; t++) begin
      bus = '0;
      for (int p = 0; p < NP; p++)
        if (tv[t].valid[p]) begin bus[64*p +: 64] = uw(k); k++; end
      cl_ready = tv[t].ready;
      cyc(tv[t].valid, bus, tv[t].last);
      chk($sformatf("t2_cnt%0d", t), 64'(upd_count), 64'(tv[t].exp_cnt));
      chk($sformatf("t2_vld%0d", t), 64'(cl_valid), 64'(tv[t].exp_vld));
      chk($sformatf("t2_last%0d", t), 64'(cl_last), 64'(tv[t].exp_last));
      chk($sformatf("t2_done%0d", t), 64'(done), 64'(tv[t].exp_done));
    end
    ln = '0;
    for (int i = 0; i < 8; i++) ln[64*i +: 64] = uw(i);
    exp_q.push_back(ln);
    ln = '0;
    ln[512] = 1'b1;
    for (int i = 0; i < 8; i++) ln[64*i +: 64] = (i < 4) ? uw(8 + i) : PAD;
    exp_q.push_back(ln);
    cmp_lines("t2");

    // Test 3: fill=7 then pipes 1 and 3 valid; pipe 3 opens the next line.
    do_start();
    cl_ready = 1'b1;
    for (int i = 0; i < 7; i++) cyc(4'b0001, (NP*64)'(uw(200 + i)), 1'b0);
    bus = {4{uw(999)}};
    bus[64*1 +: 64] = uw(300);
    bus[64*3 +: 64] = uw(301);
    cyc(4'b1010, bus, 1'b0);
    for (int i = 0; i < 7; i++) cyc(4'b0001, (NP*64)'(uw(400 + i)), 1'b0);
    repeat (3) step();
    chk("t3_count", 64'(upd_count), 64'd16);
    ln = '0;
    for (int i = 0; i < 7; i++) ln[64*i +: 64] = uw(200 + i);
    ln[64*7 +: 64] = uw(300);
    exp_q.push_back(ln);
    ln = '0;
    ln[63:0] = uw(301);
    for (int i = 1; i < 8; i++) ln[64*i +: 64] = uw(400 + i - 1);
    exp_q.push_back(ln);
    cmp_lines("t3");

    // Test 4: back-pressure past capacity drops exactly the extra line.
    do_start();
    cl_ready = 1'b0;
    for (int l = 0; l <= FD; l++) begin
      for (int h = 0; h < 2; h++) begin
        for (int p = 0; p < NP; p++) bus[64*p +: 64] = {$urandom, $urandom};
        cyc(4'hF, bus, 1'b0);
        for (int p = 0; p < NP; p++) model_accept(bus[64*p +: 64]);
      end
      if (l == FD - 1) chk("t4_ovf_before", 64'(overflow), 64'd0);
    end
    chk("t4_ovf_after", 64'(overflow), 64'd1);
    void'(exp_q.pop_back());
    cl_ready = 1'b1;
    for (int i = 0; i < 3 * FD && got_q.size() < FD; i++) step();
    repeat (3) step();
    cmp_lines("t4");

    // Test 5: end-of-input with empty staging, then updates while idle.
    do_start();
    chk("t5_ovf_clear", 64'(overflow), 64'd0);
    cyc(4'b0000, '0, 1'b1);
    wait_done("t5", 20);
    ln = '0;
    ln[512] = 1'b1;
    for (int i = 0; i < 8; i++) ln[64*i +: 64] = PAD;
    exp_q.push_back(ln);
    cmp_lines("t5");
    cyc(4'b0001, (NP*64)'(uw(7)), 1'b0);
    chk("t5_idle_ovf", 64'(overflow), 64'd1);
    chk("t5_idle_cnt", 64'(upd_count), 64'd0);
    do_start();
    chk("t5_start_ovf", 64'(overflow), 64'd0);
    chk("t5_start_cnt", 64'(upd_count), 64'd0);
    chk("t5_start_done", 64'(done), 64'd0);

    // Test 6: asynchronous reset mid-line, then a clean line.
    for (int i = 0; i < 5; i++) cyc(4'b0001, (NP*64)'(uw(500 + i)), 1'b0);
    chk("t6_pre_cnt", 64'(upd_count), 64'd5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cnt", 64'(upd_count), 64'd0);
    chk("t6_rst_valid", 64'(cl_valid), 64'd0);
    chk("t6_rst_ovf", 64'(overflow), 64'd0);
    chk_line("t6_rst_line", {cl_last, cl_out}, 513'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cl_ready = 1'b1;
    for (int i = 0; i < 8; i++) cyc(4'b0001, (NP*64)'(uw(600 + i)), 1'b0);
    repeat (3) step();
    ln = '0;
    for (int i = 0; i < 8; i++) ln[64*i +: 64] = uw(600 + i);
    exp_q.push_back(ln);
    cmp_lines("t6");

    // Randomized levels against the stream model.
    for (int lv = 0; lv < 3; lv++) begin
      do_start();
      pend_q.delete();
      exp_cnt = 32'd0;
      for (int c = 0; c < 150; c++) begin
        m = 4'($urandom_range(0, 15));
        for (int p = 0; p < NP; p++) bus[64*p +: 64] = {$urandom, $urandom};
        cl_ready = ($urandom_range(0, 3) != 0);
        cyc(m, bus, (c == 149));
        for (int p = 0; p < NP; p++) if (m[p]) model_accept(bus[64*p +: 64]);
        exp_cnt = exp_cnt + 32'($countones(m));
        chk($sformatf("rnd%0d_cnt%0d", lv, c), 64'(upd_count), 64'(exp_cnt));
      end
      model_last();
      wait_done($sformatf("rnd%0d", lv), 300);
      chk($sformatf("rnd%0d_ovf", lv), 64'(overflow), 64'd0);
      cmp_lines($sformatf("rnd%0d", lv));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
